// File: rtl/conv_pkg.sv
// conv_pkg: pixel and 2x2 window types shared by the window feeder and CNeuron
package conv_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_N = 4;
  typedef logic signed [PIX_W-1:0] pix_t;
  typedef logic [WIN_N-1:0][PIX_W-1:0] window_t;
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one-row pixel store; combinational read and clocked write share one address
// Ports: clk; i_we write enable; i_addr column; i_wdata new pixel; o_rdata pixel stored at i_addr (old value during a write)
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  pix_t          i_wdata,
  output pix_t          o_rdata
);
  pix_t r_mem [IMG_W];
  assign o_rdata = r_mem[i_addr];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end
endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: turns a raster pixel stream into a stream of 2x2 windows
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_pixel raster input;
// win_valid/win_ready/win_pixels window output ([3]=TL,[2]=TR,[1]=BL,[0]=BR);
// win_row/win_col bottom-right coordinates; frame_done pulses on the last pixel of a frame
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_pixel,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [3:0][7:0] win_pixels,
  output logic [7:0]      win_col,
  output logic [7:0]      win_row,
  output logic            frame_done
);
  localparam int AW = $clog2(IMG_W);
  localparam logic [7:0] LAST_C = 8'(IMG_W - 1);
  localparam logic [7:0] LAST_R = 8'(IMG_H - 1);
  logic [7:0] r_col, r_row;
  pix_t       r_left_top, r_left_bot;
  pix_t       w_top;
  logic       w_acc, w_gen, w_last_c, w_last_r;
  assign in_ready = !win_valid || win_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_last_c = r_col == LAST_C;
  assign w_last_r = r_row == LAST_R;
  assign w_gen    = w_acc && r_row != 8'd0 && r_col != 8'd0;
  conv_line_buffer #(.IMG_W(IMG_W), .AW(AW)) u_line (
    .clk     (clk),
    .i_we    (w_acc),
    .i_addr  (r_col[AW-1:0]),
    .i_wdata (pix_t'(in_pixel)),
    .o_rdata (w_top)
  );
  // The left column of each window is the previous accepted pixel and the
  // line-buffer word read alongside it, captured one acceptance earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_left_top <= '0;
      r_left_bot <= '0;
      win_valid  <= 1'b0;
      win_pixels <= '0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (w_acc) begin
        r_col      <= w_last_c ? 8'd0 : r_col + 8'd1;
        r_row      <= w_last_c ? (w_last_r ? 8'd0 : r_row + 8'd1) : r_row;
        r_left_top <= w_top;
        r_left_bot <= pix_t'(in_pixel);
      end
      if (w_gen) begin
        win_pixels <= {r_left_top, w_top, r_left_bot, in_pixel};
        win_row    <= r_row;
        win_col    <= r_col;
      end
      win_valid  <= w_gen || (win_valid && !win_ready);
      frame_done <= w_acc && w_last_c && w_last_r;
    end
  end
endmodule
